// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit/receive path.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } tx_feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with registered read data and registered level;
// read data only changes on an accepted pop, so it can be used as a holding register.
import uart_pkg::*;

module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = UART_BYTE_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      pop_data <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them one per frame to the UART transmitter
// through the start_tx / tx_done handshake.
import uart_pkg::*;

module uart_tx_feeder #(
  parameter  int DEPTH        = 16,
  parameter  int AFULL_THRESH = 12,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic [LW-1:0]          level,
  output logic                   overflow,
  output logic                   busy,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   start_tx,
  input  logic                   tx_done
);

  tx_feed_state_t state;
  logic           pop;

  // The FIFO read register doubles as the tx_data holding register.
  assign pop = (state == IDLE) && !empty && tx_done;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (tx_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign almost_full = (level >= LW'(AFULL_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      start_tx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= REQ;
            busy     <= 1'b1;
            start_tx <= 1'b1;
          end
        end
        REQ: begin
          // The core signals acceptance by dropping tx_done.
          if (!tx_done) begin
            state    <= BUSY;
            start_tx <= 1'b0;
          end
        end
        BUSY: begin
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          start_tx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench: accepted writes queue expected frame bytes, a monitor
// matches each new start_tx request against the queue head.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       full, almost_full, empty, overflow, busy, start_tx;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_done = 1'b1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         frames_seen = 0;
  bit         uart_auto = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .busy        (busy),
    .tx_data     (tx_data),
    .start_tx    (start_tx),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit accepted);
    wr_en   = 1'b1;
    wr_data = d;
    if (accepted) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, start_tx, 0);
    chk({tag, "_txdata"}, tx_data, 0);
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy && !start_tx) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_drain_done"}, done, 1);
  endtask

  // Monitor: every new frame request must carry the oldest outstanding byte,
  // and the byte must not change while a frame is in progress.
  initial begin
    logic       prev_start = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start = 1'b0;
      end else begin
        if (start_tx && !prev_start) begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got tx_data %0h with no byte outstanding at %0t", tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", tx_data, e);
          end
          cur_byte = tx_data;
        end else if (busy) begin
          chk("tx_data_hold", tx_data, cur_byte);
        end
        prev_start = start_tx;
      end
    end
  end

  // Behavioural UART core: accepts a request after a short random delay and
  // reports the frame busy for a random number of cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_auto && start_tx && tx_done) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        tx_done = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int fs0;
    logic [7:0] d;

    // Reset values
    repeat (3) tick();
    check_reset("reset");
    reset_n = 1'b1;
    tick();

    // Single byte latency and handshake
    wr(8'hA5, 1'b1);
    chk("lat_empty_c1", empty, 0);
    chk("lat_start_c1", start_tx, 0);
    tick();
    chk("lat_start_c2", start_tx, 1);
    chk("lat_txdata_c2", tx_data, 8'hA5);
    tx_done = 1'b0;
    tick();
    chk("req_drop_start", start_tx, 0);
    chk("req_busy", busy, 1);
    for (int i = 0; i < 99; i++) begin
      tick();
      chk("long_frame_txdata", tx_data, 8'hA5);
      chk("long_frame_start", start_tx, 0);
    end
    tx_done = 1'b1;
    tick();
    chk("frame_end_busy", busy, 0);

    // Fill while the core never accepts: a sentinel frame sits in REQ
    wr(8'h55, 1'b1);
    tick();
    chk("sentinel_start", start_tx, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      wr(8'(k - 1), 1'b1);
      chk("fill_level", level, k);
      chk("fill_afull", almost_full, (k >= 12));
      chk("fill_full", full, (k == DEPTH));
    end
    wr(8'hEE, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, DEPTH);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Drop a write while full in the very cycle a pop happens
    tx_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("popfull_ovf", overflow, 1);
    chk("popfull_level", level, DEPTH - 1);
    chk("popfull_start", start_tx, 1);
    chk("popfull_txdata", tx_data, 8'h00);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("popfull_ovf_clr", overflow, 0);
    uart_auto = 1'b1;
    drain("fill");
    uart_auto = 1'b0;

    // Simultaneous write and pop at level 5
    tx_done = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i), 1'b1);
    chk("wp_level_before", level, 5);
    tx_done = 1'b1;
    wr(8'h15, 1'b1);
    chk("wp_level_after", level, 5);
    chk("wp_start", start_tx, 1);
    chk("wp_txdata", tx_data, 8'h10);
    uart_auto = 1'b1;
    drain("wp");
    uart_auto = 1'b0;

    // Flush while a frame is in progress
    tx_done = 1'b0;
    for (int i = 0; i < 7; i++) wr(8'(8'h20 + i), 1'b1);
    tx_done = 1'b1;
    tick();
    chk("fl_start", start_tx, 1);
    tx_done = 1'b0;
    tick();
    chk("fl_level_pre", level, 6);
    chk("fl_busy_pre", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    chk("fl_level", level, 0);
    chk("fl_empty", empty, 1);
    chk("fl_busy", busy, 1);
    chk("fl_txdata", tx_data, 8'h20);
    repeat (5) tick();
    tx_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fl_no_start", start_tx, 0);
    end
    chk("fl_busy_end", busy, 0);
    chk("fl_txdata_end", tx_data, 8'h20);

    // tx_done low across reset release: no pop until it rises
    reset_n = 1'b0;
    tx_done = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    check_reset("reset2");
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) wr(8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_no_start", start_tx, 0);
      chk("hold_level", level, 3);
    end
    tx_done = 1'b1;
    tick();
    chk("rel_start", start_tx, 1);
    chk("rel_txdata", tx_data, 8'h30);
    chk("rel_level", level, 2);
    // Asynchronous reset in the middle of REQ, checked before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async");
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized traffic against the auto-responding core
    uart_auto = 1'b1;
    pushed = 0;
    fs0 = frames_seen;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1 && (pushed - (frames_seen - fs0)) < DEPTH) begin
        d = 8'($urandom);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    drain("rand");
    chk("rand_frames", frames_seen - fs0, pushed);
    chk("rand_ovf", overflow, 0);
    chk("rand_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer and sequencer that sits directly upstream of the UART core's transmitter. The host side writes bytes into an internal FIFO at any rate. The block pops them one at a time, presents each on `tx_data`, and drives the `start_tx` / `tx_done` handshake so that every byte becomes exactly one UART frame, with `tx_data` held stable for the whole frame.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 4.
- `AFULL_THRESH`, default 12: `almost_full` asserts when level ≥ this value; range 1..DEPTH.
- `clk`, in, 1: system clock, the same clock as the UART core.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: host write strobe, one byte per cycle.
- `wr_data`, in, 8: host byte.
- `flush`, in, 1: synchronous clear of FIFO contents.
- `clr_ovf`, in, 1: clears `overflow`.
- `full`, out, 1: level == DEPTH.
- `almost_full`, out, 1: level ≥ `AFULL_THRESH`.
- `empty`, out, 1: level == 0.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`, out, 1: sticky flag; set when a write is dropped.
- `busy`, out, 1: FSM is not in IDLE.
- `tx_data`, out, 8: byte to the UART core; held for the whole frame.
- `start_tx`, out, 1: frame request to the UART core.
- `tx_done`, in, 1: UART core status; 1 = idle or frame complete, 0 = frame in progress.

## Operation
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `level` is a registered count.
- Write:
  - Accepted when `wr_en` && !`full` (registered `full`).
  - A write while `full` is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: `level` is unchanged and both pointers advance.
- FSM states: IDLE, REQ, BUSY.
  - IDLE: when !`empty` && `tx_done`==1, pop the head into the `tx_data` holding register and go to REQ. Otherwise stay in IDLE.
  - REQ: `start_tx`=1. Stay until `tx_done`==0 is sampled (the core has accepted the frame), then go to BUSY. The wait is unbounded, because the core gates acceptance on its baud tick and `cts_n`.
  - BUSY: `start_tx`=0. Stay until `tx_done`==1, then go to IDLE.
- `tx_data` changes only on the IDLE→REQ transition and is otherwise held.
- `flush`:
  - Zeroes both pointers and `level` in the same cycle.
  - Overrides any write or pop in that cycle.
  - Does not affect the FSM, `tx_data`, or an in-flight frame.
- `clr_ovf` clears `overflow`. If a dropped write occurs in the same cycle, set wins.
- Reset values:
  - `level`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0.
  - FSM=IDLE, `busy`=0, `start_tx`=0, `tx_data`=8'h00.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from `wr_en` or `tx_done` to any output.
- Latency from write into an empty FIFO with `tx_done`=1:
  - `wr_en` in cycle 0.
  - `empty`=0 in cycle 1.
  - Pop in cycle 1.
  - `start_tx`=1 and valid `tx_data` in cycle 2.
- From `tx_done` 0 sampled in REQ: `start_tx`=0 in the next cycle.
- Back-to-back bytes: after `tx_done` rises in BUSY, the FSM is in IDLE one cycle later and `start_tx` reasserts one cycle after that. Minimum gap is 2 clocks of `tx_done`=1.
- If `tx_done`==0 at reset release (the core is mid-frame), the feeder waits in IDLE and does not pop.
- Reset mid-frame:
  - The feeder returns immediately to reset values and FIFO contents are lost.
  - An in-progress frame in the core is not the feeder's concern.

## Structure
- Shared package `uart_pkg`:
  - `tx_feed_state_t` enum {IDLE, REQ, BUSY}.
  - `UART_BYTE_W` = 8.
- One natural sub-module: `uart_sync_fifo`, with parameters DEPTH and WIDTH. It provides push/pop/flush, full/empty/level and registered outputs, and is reusable later as the RX buffer.
- The FSM and handshake logic live in `uart_tx_feeder`.

## Test plan
- Reset, then write 8'hA5 with `tx_done`=1. Required response: `start_tx`=1 with `tx_data`=8'hA5 two cycles after `wr_en`. Then drive `tx_done`=0, hold it for 100 cycles, and return it to 1. Required response: `start_tx` drops one cycle after `tx_done` falls, `tx_data` stays 8'hA5 throughout, and `busy` returns to 0.
- Write 16 bytes 8'h00..8'h0F in consecutive cycles, with the UART model stalled at `tx_done`=1 and never accepting. Required responses:
  - `full`=1.
  - `almost_full` asserts on the 12th accepted write.
  - A 17th write sets `overflow`.
  - Releasing the model then produces frames in order 8'h00..8'h0F with none lost or duplicated.
- Write and pop in the same cycle at level 5. Required response: `level` stays 5 and order is preserved. Also write while `full` with a pop in the same cycle. Required response: write dropped and `overflow`=1.
- Assert `flush` while in BUSY with 6 bytes queued. Required responses:
  - `level`=0 next cycle.
  - The current frame completes with `tx_data` unchanged.
  - No further `start_tx`.
- Hold `tx_done`=0 through reset release with 3 bytes written. Required response: no pop and `start_tx`=0 until `tx_done` rises. Also assert reset mid-REQ. Required response: all outputs return to their reset values asynchronously.
